// File: rtl/rom_scan_ctrl.sv
// Sequential scan controller for NUM_BANKS 8x8 ROM banks: reads a linear byte range
// with wrap and presents each byte on a valid/ready output. Optional: ROM_SCAN_CHECKSUM_EN.
`timescale 1ns/1ps
module rom_scan_ctrl #(
  parameter int NUM_BANKS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           start_addr,
  input  logic [4:0]           length,
  output logic [NUM_BANKS-1:0] cs,
  output logic [2:0]           addrb,
  output logic                 read_en,
  input  logic [7:0]           datab,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef ROM_SCAN_CHECKSUM_EN
  ,
  output logic [7:0]           checksum
`endif
);

  localparam int ADDR_SPACE = NUM_BANKS * 8;
  localparam logic [5:0] ADDR_LIMIT = 6'(ADDR_SPACE);
  localparam logic [4:0] LAST_ADDR  = 5'(ADDR_SPACE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] cur_addr;
  logic [4:0] remaining;
  logic [4:0] remaining_dec;
  logic [4:0] addr_inc;
  logic       start_take;
  logic       start_legal;
  logic       byte_take;

  // Output handshake: a byte transfers on a rising edge where out_valid and
  // out_ready are both 1; out_data/out_last stay frozen while out_valid is 1
  // and out_ready is 0, and the producer never withdraws a presented byte.
  assign start_take    = (state == IDLE) && start;
  assign start_legal   = ({1'b0, start_addr} < ADDR_LIMIT);
  assign byte_take     = (state == HOLD) && out_valid && out_ready;
  assign remaining_dec = remaining - 5'd1;
  assign addr_inc      = (cur_addr == LAST_ADDR) ? 5'd0 : cur_addr + 5'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!start_legal || (length == 5'd0)) begin
            state_next = FIN;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: state_next = HOLD;
      HOLD: begin
        if (byte_take) begin
          state_next = (remaining_dec != 5'd0) ? ISSUE : FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; the ROM port is idle (all zero) outside ISSUE.
  always_comb begin
    read_en = 1'b0;
    addrb   = 3'd0;
    cs      = '0;
    busy    = (state != IDLE);
    done    = (state == FIN);
    if (state == ISSUE) begin
      read_en = 1'b1;
      addrb   = cur_addr[2:0];
      for (int k = 0; k < NUM_BANKS; k++) begin
        cs[k] = (cur_addr[4:3] == 2'(k));
      end
    end
  end

  // Scan pointer and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= 5'd0;
      remaining <= 5'd0;
    end else if (start_take && start_legal) begin
      cur_addr  <= start_addr;
      remaining <= length;
    end else if (byte_take) begin
      remaining <= remaining_dec;
      if (remaining_dec != 5'd0) begin
        cur_addr <= addr_inc;
      end
    end
  end

  // Output byte register: the ROM answers within the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (state == ISSUE) begin
      out_data  <= datab;
      out_valid <= 1'b1;
      out_last  <= (remaining == 5'd1);
    end else if (byte_take) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // err is sticky until the next legal start is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start_take) begin
      err <= !start_legal;
    end
  end

`ifdef ROM_SCAN_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 8'd0;
    end else if (start_take) begin
      checksum <= 8'd0;
    end else if (byte_take) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl: bank model, scoreboard queues for ROM reads and
// output bytes, monitor on the falling edge, final summary.
`timescale 1ns/1ps
module tb_rom_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] start_addr = 5'd0;
  logic [4:0] length = 5'd0;
  logic [2:0] cs;
  logic [2:0] addrb;
  logic       read_en;
  logic [7:0] datab;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;
`ifdef ROM_SCAN_CHECKSUM_EN
  logic [7:0] checksum;
`endif
  logic [7:0] exp_sum = 8'd0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_acc_cyc = -1;
  int last_acc_cyc = -1;

  logic [8:0] exp_q[$];
  logic [5:0] rd_q[$];

  rom_scan_ctrl #(.NUM_BANKS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .cs         (cs),
    .addrb      (addrb),
    .read_en    (read_en),
    .datab      (datab),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef ROM_SCAN_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bank model ----------------
  function automatic logic [7:0] bank_byte(input int k, input logic [2:0] i);
    return 8'(k * 64 + 10 * int'(i));
  endfunction

  always_comb begin
    datab = 8'd0;
    for (int k = 0; k < 3; k++) begin
      if (read_en && cs[k]) datab = datab | bank_byte(k, addrb);
    end
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, cs, 0);
    check({tag, "_addrb"}, addrb, 0);
    check({tag, "_read_en"}, read_en, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
`ifdef ROM_SCAN_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_scan();
    exp_sum = 8'd0;
    first_acc_cyc = -1;
    last_acc_cyc = -1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
    exp_sum = exp_sum + d;
  endtask

  task automatic expect_rd(input logic [2:0] c, input logic [2:0] a);
    rd_q.push_back({c, a});
  endtask

  task automatic expect_rd_addr(input logic [4:0] a);
    logic [2:0] one;
    one = 3'b001;
    expect_rd(one << a[4:3], a[2:0]);
  endtask

  task automatic do_start(input logic [4:0] a, input logic [4:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    length = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done; optionally pulses start during the FIN cycle.
  task automatic wait_done(input string name, input int budget, input bit chk_lat, input bit fin_start);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      fail({name, "_done_timeout"});
    end else begin
      if (chk_lat) check({name, "_done_latency"}, cyc, last_acc_cyc + 1);
      check({name, "_bytes_left"}, exp_q.size(), 0);
      check({name, "_reads_left"}, rd_q.size(), 0);
`ifdef ROM_SCAN_CHECKSUM_EN
      check({name, "_checksum"}, checksum, exp_sum);
`endif
      if (fin_start) begin
        start = 1'b1;
        start_addr = 5'd4;
        length = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      @(negedge clk);
      check({name, "_done_width"}, done, 0);
      check({name, "_idle_busy"}, busy, 0);
`ifdef ROM_SCAN_CHECKSUM_EN
      check({name, "_checksum_hold"}, checksum, exp_sum);
`endif
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) fail({name, "_valid_timeout"});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_en) begin
        if (rd_q.size() == 0) begin
          fail("unexpected_read");
        end else begin
          logic [5:0] e;
          e = rd_q.pop_front();
          check("rd_cs", cs, e[5:3]);
          check("rd_addrb", addrb, e[2:0]);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_byte");
        end else begin
          logic [8:0] b;
          b = exp_q.pop_front();
          check("byte_data", out_data, b[7:0]);
          check("byte_last", out_last, b[8]);
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          if (b[8]) last_acc_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] s1[8];
    s1 = '{8'd128, 8'd138, 8'd148, 8'd158, 8'd168, 8'd178, 8'd188, 8'd198};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Scan 1: bank2 in full, throughput 1 byte per 2 cycles
    new_scan();
    for (int i = 0; i < 8; i++) begin
      expect_rd_addr(5'(16 + i));
      expect_byte(s1[i], i == 7);
    end
    do_start(5'd16, 5'd8);
    wait_done("scan1", 60, 1'b1, 1'b0);
    check("scan1_throughput", last_acc_cyc - first_acc_cyc, 14);
`ifdef ROM_SCAN_CHECKSUM_EN
    check("scan1_checksum_value", checksum, 8'h18);
`endif

    // Scan 2: wrap from bank2 into bank0
    new_scan();
    expect_rd(3'b100, 3'd6); expect_byte(8'd188, 1'b0);
    expect_rd(3'b100, 3'd7); expect_byte(8'd198, 1'b0);
    expect_rd(3'b001, 3'd0); expect_byte(8'd0, 1'b0);
    expect_rd(3'b001, 3'd1); expect_byte(8'd10, 1'b1);
    do_start(5'd22, 5'd4);
    wait_done("scan2", 40, 1'b1, 1'b0);

    // Scan 3: backpressure on the first byte
    new_scan();
    out_ready = 1'b0;
    expect_rd_addr(5'd5); expect_byte(8'd50, 1'b0);
    expect_rd_addr(5'd6); expect_byte(8'd60, 1'b1);
    do_start(5'd5, 5'd2);
    wait_valid("scan3", 10);
    for (int i = 0; i < 5; i++) begin
      check("scan3_hold_data", out_data, 8'd50);
      check("scan3_hold_valid", out_valid, 1);
      check("scan3_hold_last", out_last, 0);
      check("scan3_hold_no_read", read_en, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("scan3", 30, 1'b1, 1'b0);

    // Scan 4: illegal start address, then a legal start clears err
    new_scan();
    do_start(5'd25, 5'd3);
    check("scan4_err_set", err, 1);
    check("scan4_busy", busy, 1);
    wait_done("scan4", 10, 1'b0, 1'b0);
    check("scan4_err_sticky", err, 1);
    new_scan();
    expect_rd_addr(5'd0); expect_byte(8'd0, 1'b1);
    do_start(5'd0, 5'd1);
    check("scan4_err_cleared", err, 0);
    wait_done("scan4b", 20, 1'b1, 1'b0);

    // Scan 5: zero length, then a full 24-byte scan with starts during busy and FIN
    new_scan();
    do_start(5'd3, 5'd0);
    check("scan5_len0_no_valid", out_valid, 0);
    wait_done("scan5a", 10, 1'b0, 1'b0);
    new_scan();
    for (int a = 0; a < 24; a++) begin
      expect_rd_addr(5'(a));
      expect_byte(8'((a / 8) * 64 + 10 * (a % 8)), a == 23);
    end
    do_start(5'd0, 5'd24);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; start_addr = 5'd10; length = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("scan5b", 120, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("scan5_fin_start_ignored", busy, 0);
      @(negedge clk);
    end

    // Scan 6: asynchronous reset while holding a byte
    new_scan();
    out_ready = 1'b0;
    expect_rd_addr(5'd8); expect_byte(8'd64, 1'b0);
    do_start(5'd8, 5'd8);
    wait_valid("scan6", 10);
    check("scan6_pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("scan6_async");
    exp_q.delete();
    rd_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("scan6_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    new_scan();
    expect_rd_addr(5'd2); expect_byte(8'd20, 1'b0);
    expect_rd_addr(5'd3); expect_byte(8'd30, 1'b0);
    expect_rd_addr(5'd4); expect_byte(8'd40, 1'b1);
    do_start(5'd2, 5'd3);
    wait_done("scan6b", 30, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
